// File: rtl/async_fifo_pkg.sv
// Shared constants, FSM state encoding and Gray helper for the async FIFO pointer logic.
package async_fifo_pkg;

  localparam int ADDR_W     = 3;
  localparam int PTR_W      = ADDR_W + 1;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int GRAY_MAX_W = 16;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  // Zero-extended inputs convert correctly, so one wide helper serves every pointer width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_chain.sv
// Generic WIDTH x STAGES flop synchronizer with async active-low reset.
module ptr_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= {stage_q[STAGES-2:0], d_i};
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/r2w_ptr_sync.sv
// Write-domain read-pointer synchronizer with fill level, almost-full and startup-valid.
// Gray-integrity monitor is built only when R2W_SYNC_ERR_CHECK_EN is defined.
//
// state     | meaning
// WARMUP    | synchronizer flushing; level/almost-full held at 0, checks off
// RUN       | outputs live until reset
module r2w_ptr_sync #(
  parameter int ADDR_W      = async_fifo_pkg::ADDR_W,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_W      = ADDR_W + 1
) (
  input  logic             i_wclk,
  input  logic             i_rst_n,
  input  logic [PTR_W-1:0] i_g_r_ptr,
  input  logic [PTR_W-1:0] i_g_w_ptr,
  input  logic [PTR_W-1:0] i_af_thresh,
  input  logic             i_err_clr,
  output logic [PTR_W-1:0] o_g_r_ptr_sync,
  output logic [PTR_W-1:0] o_wlevel,
  output logic             o_almost_full,
  output logic             o_sync_valid,
  output logic             o_gray_err,
  output logic [7:0]       o_err_cnt
);
  import async_fifo_pkg::*;

  localparam logic [PTR_W-1:0] LVL_MAX   = PTR_W'(1 << ADDR_W);
  localparam logic [2:0]       WARM_INIT = 3'(SYNC_STAGES);

  logic [PTR_W-1:0] g_r_sync, r_bin, w_bin, raw, lvl_sat;
  logic             overflow, run;
  logic [0:0]       state_q, state_d;
  logic [2:0]       warm_cnt_q, warm_cnt_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             af_q, af_d;

  ptr_sync_chain #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (i_wclk),
    .rst_ni (i_rst_n),
    .d_i    (i_g_r_ptr),
    .q_o    (g_r_sync)
  );

  assign r_bin    = PTR_W'(gray2bin(GRAY_MAX_W'(g_r_sync)));
  assign w_bin    = PTR_W'(gray2bin(GRAY_MAX_W'(i_g_w_ptr)));
  assign raw      = w_bin - r_bin;
  assign overflow = raw > LVL_MAX;
  assign lvl_sat  = overflow ? LVL_MAX : raw;
  assign run      = (state_q == ST_RUN);

  // Terminal count at zero gives SYNC_STAGES+1 edges of warm-up.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (state_q == ST_WARMUP) begin
      if (warm_cnt_q == 3'd0) state_d    = ST_RUN;
      else                    warm_cnt_d = warm_cnt_q - 3'd1;
    end
  end

  assign wlevel_d = run ? lvl_sat : '0;
  assign af_d     = run && (lvl_sat >= i_af_thresh);

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_WARMUP;
      warm_cnt_q <= WARM_INIT;
      wlevel_q   <= '0;
      af_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      wlevel_q   <= wlevel_d;
      af_q       <= af_d;
    end
  end

  assign o_g_r_ptr_sync = g_r_sync;
  assign o_wlevel       = wlevel_q;
  assign o_almost_full  = af_q;
  assign o_sync_valid   = run;

`ifdef R2W_SYNC_ERR_CHECK_EN
  logic [PTR_W-1:0] g_prev_q, g_diff;
  logic             multi_bit, err_now;
  logic             gray_err_q, gray_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign g_diff    = g_r_sync ^ g_prev_q;
  assign multi_bit = |(g_diff & (g_diff - PTR_W'(1)));
  assign err_now   = run && (multi_bit || overflow);

  always_comb begin
    gray_err_d = gray_err_q;
    err_cnt_d  = err_cnt_q;
    if (i_err_clr) begin
      gray_err_d = err_now;
      err_cnt_d  = err_now ? 8'd1 : 8'd0;
    end else if (err_now) begin
      gray_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      g_prev_q   <= '0;
      gray_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      g_prev_q   <= g_r_sync;
      gray_err_q <= gray_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_gray_err = gray_err_q;
  assign o_err_cnt  = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_gray_err     = 1'b0;
  assign o_err_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_r2w_ptr_sync.sv
// Self-checking bench for r2w_ptr_sync (ADDR_W=3, SYNC_STAGES=2); follows R2W_SYNC_ERR_CHECK_EN.
module tb_r2w_ptr_sync;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 8;
`ifdef R2W_SYNC_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       i_wclk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_g_r_ptr = '0, i_g_w_ptr = '0, i_af_thresh = '0;
  logic       i_err_clr = 1'b0;
  logic [3:0] o_g_r_ptr_sync, o_wlevel;
  logic       o_almost_full, o_sync_valid, o_gray_err;
  logic [7:0] o_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  r2w_ptr_sync #(.ADDR_W(3), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_wclk         (i_wclk),
    .i_rst_n        (i_rst_n),
    .i_g_r_ptr      (i_g_r_ptr),
    .i_g_w_ptr      (i_g_w_ptr),
    .i_af_thresh    (i_af_thresh),
    .i_err_clr      (i_err_clr),
    .o_g_r_ptr_sync (o_g_r_ptr_sync),
    .o_wlevel       (o_wlevel),
    .o_almost_full  (o_almost_full),
    .o_sync_valid   (o_sync_valid),
    .o_gray_err     (o_gray_err),
    .o_err_cnt      (o_err_cnt)
  );

  always #5 i_wclk = ~i_wclk;

  // Gray decode by search: the n whose Gray code equals g.
  function automatic int g2b(input logic [3:0] g);
    for (int n = 0; n < 16; n++) if (4'(n ^ (n >> 1)) == g) return n;
    return 0;
  endfunction

  function automatic logic [3:0] b2g(input int n);
    return 4'(n ^ (n >> 1));
  endfunction

  // Reference model: delay line of sampled read pointers plus modular arithmetic.
  logic [3:0] m_hist [SYNC_STAGES];
  logic [3:0] m_prev = '0;
  int         m_edges = 0;
  logic [3:0] e_level = '0;
  logic       e_af = 1'b0, e_err = 1'b0;
  int         e_cnt = 0;
  logic [3:0] e_sync;
  logic       e_valid;

  assign e_sync  = m_hist[SYNC_STAGES-1];
  assign e_valid = (m_edges >= SYNC_STAGES + 1);

  always @(posedge i_wclk or negedge i_rst_n) begin : model
    int  raw, lvl;
    bit  run, bad;
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] <= '0;
      m_prev  <= '0;
      m_edges <= 0;
      e_level <= '0;
      e_af    <= 1'b0;
      e_err   <= 1'b0;
      e_cnt   <= 0;
    end else begin
      run = (m_edges >= SYNC_STAGES + 1);
      raw = (g2b(i_g_w_ptr) - g2b(m_hist[SYNC_STAGES-1]) + 16) % 16;
      lvl = (raw > DEPTH) ? DEPTH : raw;
      bad = run && (($countones(m_hist[SYNC_STAGES-1] ^ m_prev) > 1) || (raw > DEPTH));
      e_level <= run ? 4'(lvl) : 4'd0;
      e_af    <= run && (lvl >= int'(i_af_thresh));
      if (ERR_EN) begin
        if (i_err_clr) begin
          e_err <= bad;
          e_cnt <= bad ? 1 : 0;
        end else if (bad) begin
          e_err <= 1'b1;
          e_cnt <= (e_cnt >= 255) ? 255 : e_cnt + 1;
        end
      end
      m_prev <= m_hist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] <= m_hist[i-1];
      m_hist[0] <= i_g_r_ptr;
      if (m_edges < 1000) m_edges <= m_edges + 1;
    end
  end

  task automatic test_reset();
    logic [20:0] all_out;
    i_rst_n = 1'b0;
    i_g_r_ptr = '0; i_g_w_ptr = '0; i_af_thresh = '0; i_err_clr = 1'b0;
    repeat (3) @(negedge i_wclk);
    all_out = {o_g_r_ptr_sync, o_wlevel, o_almost_full, o_sync_valid, o_gray_err, o_err_cnt};
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    i_rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge i_wclk);
      n_vec++;
      if (o_sync_valid !== (e == 3)) begin
        n_err++; $display("FAIL warmup_valid edge %0d: got %b expected %b", e, o_sync_valid, (e == 3));
      end
      n_vec++;
      if ({o_wlevel, o_almost_full} !== 5'd0) begin
        n_err++; $display("FAIL warmup_hold edge %0d: got level %0d af %b expected 0/0", e, o_wlevel, o_almost_full);
      end
    end
    @(negedge i_wclk);
    n_vec++;
    if (o_almost_full !== 1'b1) begin
      n_err++; $display("FAIL af_thresh_zero: got %b expected 1", o_almost_full);
    end
  endtask

  task automatic test_latency();
    i_g_w_ptr = b2g(1); i_g_r_ptr = 4'b0000; i_af_thresh = 4'd8;
    repeat (4) @(negedge i_wclk);
    n_vec++;
    if (o_wlevel !== 4'd1) begin
      n_err++; $display("FAIL latency_pre_level: got %0d expected 1", o_wlevel);
    end
    i_g_r_ptr = 4'b0001;
    @(negedge i_wclk);
    n_vec++;
    if (o_g_r_ptr_sync !== 4'b0000) begin
      n_err++; $display("FAIL latency_sync_e1: got %b expected 0000", o_g_r_ptr_sync);
    end
    @(negedge i_wclk);
    n_vec++;
    if (o_g_r_ptr_sync !== 4'b0001 || o_wlevel !== 4'd1) begin
      n_err++; $display("FAIL latency_e2: got sync %b level %0d expected 0001/1", o_g_r_ptr_sync, o_wlevel);
    end
    @(negedge i_wclk);
    n_vec++;
    if (o_wlevel !== 4'd0) begin
      n_err++; $display("FAIL latency_level_e3: got %0d expected 0", o_wlevel);
    end
  endtask

  task automatic test_level_wrap();
    i_af_thresh = 4'd6; i_g_w_ptr = 4'b1101; i_g_r_ptr = 4'b0010;
    repeat (4) @(negedge i_wclk);
    n_vec++;
    if (o_wlevel !== 4'd6 || o_almost_full !== 1'b1) begin
      n_err++; $display("FAIL level_6: got %0d af %b expected 6/1", o_wlevel, o_almost_full);
    end
    i_g_r_ptr = 4'b0110;
    repeat (4) @(negedge i_wclk);
    n_vec++;
    if (o_wlevel !== 4'd5 || o_almost_full !== 1'b0) begin
      n_err++; $display("FAIL level_5: got %0d af %b expected 5/0", o_wlevel, o_almost_full);
    end
    i_g_w_ptr = 4'b1100; i_g_r_ptr = 4'b0000;
    repeat (4) @(negedge i_wclk);
    n_vec++;
    if (o_wlevel !== 4'd8 || o_almost_full !== 1'b1) begin
      n_err++; $display("FAIL level_wrap_8: got %0d af %b expected 8/1", o_wlevel, o_almost_full);
    end
    i_af_thresh = 4'd9;
    repeat (2) @(negedge i_wclk);
    n_vec++;
    if (o_almost_full !== 1'b0) begin
      n_err++; $display("FAIL af_thresh_above_depth: got %b expected 0", o_almost_full);
    end
  endtask

  task automatic test_gray_err();
    logic [3:0] r;
    i_af_thresh = 4'd8; i_g_w_ptr = 4'b0011; i_g_r_ptr = 4'b0000;
    repeat (4) @(negedge i_wclk);
    i_err_clr = 1'b1;
    @(negedge i_wclk);
    i_err_clr = 1'b0;
    n_vec++;
    if (o_gray_err !== 1'b0 || o_err_cnt !== 8'd0) begin
      n_err++; $display("FAIL err_clr_start: got %b/%0d expected 0/0", o_gray_err, o_err_cnt);
    end
    i_g_r_ptr = 4'b0011;
    repeat (2) @(negedge i_wclk);
    n_vec++;
    if (o_gray_err !== 1'b0) begin
      n_err++; $display("FAIL gray_err_early: got %b expected 0", o_gray_err);
    end
    @(negedge i_wclk);
    n_vec++;
    if (o_gray_err !== ERR_EN || o_err_cnt !== 8'(ERR_EN)) begin
      n_err++; $display("FAIL gray_jump: got %b/%0d expected %b/%0d", o_gray_err, o_err_cnt, ERR_EN, ERR_EN);
    end
    r = 4'b0011;
    for (int i = 0; i < 300; i++) begin
      r = (r == 4'b0000) ? 4'b0011 : 4'b0000;
      i_g_r_ptr = r;
      @(negedge i_wclk);
    end
    repeat (4) @(negedge i_wclk);
    n_vec++;
    if (o_err_cnt !== (ERR_EN ? 8'd255 : 8'd0) || o_gray_err !== ERR_EN) begin
      n_err++; $display("FAIL err_cnt_saturate: got %b/%0d expected %b/%0d", o_gray_err, o_err_cnt, ERR_EN, ERR_EN ? 255 : 0);
    end
  endtask

  task automatic test_err_clr();
    i_g_r_ptr = (i_g_r_ptr == 4'b0000) ? 4'b0011 : 4'b0000;
    repeat (2) @(negedge i_wclk);
    i_err_clr = 1'b1;
    @(negedge i_wclk);
    i_err_clr = 1'b0;
    n_vec++;
    if (o_gray_err !== ERR_EN || o_err_cnt !== 8'(ERR_EN)) begin
      n_err++; $display("FAIL clr_with_err: got %b/%0d expected %b/%0d", o_gray_err, o_err_cnt, ERR_EN, ERR_EN);
    end
    i_err_clr = 1'b1;
    @(negedge i_wclk);
    i_err_clr = 1'b0;
    n_vec++;
    if (o_gray_err !== 1'b0 || o_err_cnt !== 8'd0) begin
      n_err++; $display("FAIL clr_alone: got %b/%0d expected 0/0", o_gray_err, o_err_cnt);
    end
  endtask

  task automatic test_random();
    int rb;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_wclk);
      n_vec++;
      if (o_g_r_ptr_sync !== e_sync) begin
        n_err++; $display("FAIL rnd_sync c%0d: got %b expected %b", c, o_g_r_ptr_sync, e_sync);
      end
      n_vec++;
      if (o_wlevel !== e_level || o_almost_full !== e_af) begin
        n_err++; $display("FAIL rnd_level c%0d: got %0d/%b expected %0d/%b", c, o_wlevel, o_almost_full, e_level, e_af);
      end
      n_vec++;
      if (o_sync_valid !== e_valid) begin
        n_err++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, o_sync_valid, e_valid);
      end
      n_vec++;
      if (o_gray_err !== e_err || o_err_cnt !== 8'(e_cnt)) begin
        n_err++; $display("FAIL rnd_err c%0d: got %b/%0d expected %b/%0d", c, o_gray_err, o_err_cnt, e_err, e_cnt);
      end
      rb = g2b(i_g_r_ptr);
      case ($urandom_range(0, 7))
        0:       i_g_r_ptr = 4'($urandom_range(0, 15));
        1, 2:    i_g_r_ptr = i_g_r_ptr;
        default: i_g_r_ptr = b2g((rb + 1) % 16);
      endcase
      if ($urandom_range(0, 3) == 0)
        i_g_w_ptr = b2g((g2b(i_g_r_ptr) + int'($urandom_range(0, 10))) % 16);
      if ($urandom_range(0, 7) == 0) i_af_thresh = 4'($urandom_range(0, 10));
      i_err_clr = ($urandom_range(0, 15) == 0);
    end
    i_err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [20:0] all_out;
    i_af_thresh = 4'd8; i_g_w_ptr = 4'b1101; i_g_r_ptr = b2g(4);
    repeat (5) @(negedge i_wclk);
    n_vec++;
    if (o_wlevel !== 4'd5) begin
      n_err++; $display("FAIL pre_reset_level: got %0d expected 5", o_wlevel);
    end
    @(posedge i_wclk);
    #2 i_rst_n = 1'b0;
    #1;
    all_out = {o_g_r_ptr_sync, o_wlevel, o_almost_full, o_sync_valid, o_gray_err, o_err_cnt};
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL async_reset: got %h expected 0", all_out);
    end
    @(negedge i_wclk);
    i_rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge i_wclk);
      n_vec++;
      if (o_sync_valid !== (e == 3)) begin
        n_err++; $display("FAIL rerelease_valid edge %0d: got %b expected %b", e, o_sync_valid, (e == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_level_wrap();
    test_gray_err();
    test_err_clr();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/r2w_ptr_sync.md
Name: r2w_ptr_sync

Overview:
- Write-domain front end for the read pointer; sits directly upstream of the write-pointer/full-flag handler.
- Brings the read-domain Gray read pointer into i_wclk through a multi-flop synchronizer and supplies the synchronized Gray pointer to the full logic.
- Also produces a registered write-side fill level, an almost-full flag, a startup-valid indication, and Gray-integrity error monitoring.

Parameters:
- ADDR_W, 3, FIFO address width; DEPTH = 2**ADDR_W, PTR_W = ADDR_W+1.
- SYNC_STAGES, 2, synchronizer flop count; legal range 2..4.

Ports:
- i_wclk  in  1  write-domain clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_g_r_ptr  in  PTR_W  Gray read pointer, launched from the read clock domain (asynchronous to i_wclk).
- i_g_w_ptr  in  PTR_W  current Gray write pointer, registered in i_wclk.
- i_af_thresh  in  PTR_W  almost-full threshold in entries, 0..DEPTH.
- i_err_clr  in  1  single-cycle clear of error flag and error counter.
- o_g_r_ptr_sync  out  PTR_W  synchronized Gray read pointer, i.e. the last synchronizer stage.
- o_wlevel  out  PTR_W  occupancy as seen by the write side, 0..DEPTH.
- o_almost_full  out  1  registered: o_wlevel >= threshold.
- o_sync_valid  out  1  high once the synchronizer has flushed after reset.
- o_gray_err  out  1  sticky integrity error.
- o_err_cnt  out  8  saturating error count.

Behaviour:
- Reset values: all synchronizer stages 0, FSM in WARMUP, and every output 0.
- Synchronizer:
  - SYNC_STAGES flops clocked by i_wclk; no logic between stages.
  - o_g_r_ptr_sync follows i_g_r_ptr with SYNC_STAGES edges of latency.
- Gray-to-binary conversion: r_bin[i] = XOR of g[PTR_W-1:i]. The same conversion is applied to i_g_w_ptr.
- Level:
  - raw = (w_bin - r_bin) mod 2**PTR_W.
  - Registered into o_wlevel one edge after o_g_r_ptr_sync updates, so total latency is SYNC_STAGES+1.
  - Wrap-around is handled by the modulo arithmetic.
  - raw > DEPTH is illegal: o_wlevel saturates at DEPTH and an integrity error is raised.
- Almost-full:
  - o_almost_full is registered in the same edge as o_wlevel and uses the new level.
  - i_af_thresh = 0 gives constant 1 (in RUN).
  - i_af_thresh > DEPTH gives constant 0.
- FSM WARMUP -> RUN:
  - WARMUP counts SYNC_STAGES+1 edges after reset release, then moves to RUN.
  - o_sync_valid = 1 only in RUN.
  - In WARMUP, o_wlevel and o_almost_full are held at 0 and error checks are suppressed.
  - RUN is held until reset. Reset asserted mid-operation returns everything to reset values and WARMUP asynchronously.
- Integrity check (RUN only), a registered comparison of the current vs previous o_g_r_ptr_sync:
  - Hamming distance > 1 is an error.
  - Distance 0 or 1 is legal.
  - Level overflow (raw > DEPTH) is also an error.
  - Each error cycle sets o_gray_err and increments o_err_cnt, saturating at 255.
  - Simultaneous error and overflow in one cycle count as a single increment.
- Error clear:
  - i_err_clr clears o_gray_err and o_err_cnt on the next edge.
  - If a new error occurs in the same cycle as i_err_clr, the result is o_gray_err = 1 and o_err_cnt = 1.

Optional Feature:
- Macro R2W_SYNC_ERR_CHECK_EN.
- Defined: the integrity check, o_gray_err and o_err_cnt behave as described above.
- Undefined:
  - No check logic is built and o_gray_err and o_err_cnt are tied to 0.
  - i_err_clr is ignored.
  - Level saturation at DEPTH still applies.

Decomposition:
- Package async_fifo_pkg: ADDR_W, PTR_W and DEPTH constants, the FSM state encoding (WARMUP, RUN), and a gray2bin function.
- One sub-module, ptr_sync_chain: generic WIDTH x SYNC_STAGES synchronizer with async active-low reset. It is instantiated once here and reused by the mirror block on the read side.

Test Plan (all with ADDR_W=3, SYNC_STAGES=2):
- Reset release, then idle inputs -> all outputs stay 0; o_sync_valid rises at the 3rd i_wclk edge after release.
- In RUN, i_g_r_ptr 0000->0001 before edge k -> o_g_r_ptr_sync = 0001 at edge k+2; o_wlevel updates at edge k+3.
- Level and wrap:
  - i_g_w_ptr = 1101 (bin 9), i_g_r_ptr = 0010 (bin 3), i_af_thresh = 6 -> o_wlevel = 6, o_almost_full = 1.
  - Then i_g_r_ptr = 0110 (bin 4) -> o_wlevel = 5, o_almost_full = 0.
  - Then i_g_w_ptr = 1100 (bin 8), i_g_r_ptr = 0000 -> o_wlevel = 8.
- With the macro defined, in RUN, i_g_r_ptr jumps 0000->0011 (2-bit change) -> o_gray_err = 1 and o_err_cnt = 1, one edge after o_g_r_ptr_sync changes. Repeated bad jumps saturate o_err_cnt at 255.
- i_err_clr asserted in the same cycle as a new 2-bit jump -> o_err_cnt = 1, o_gray_err = 1. i_err_clr alone -> both 0 on the next edge.
- Assert i_rst_n low mid-RUN with o_wlevel = 5 -> all outputs 0 immediately, without waiting for a clock edge. After release, o_sync_valid is low for 2 edges and high on the 3rd.
